// File: rtl/store_pkg.sv
// Shared types for the store narrowing path: size codes, FSM states, the
// per-beat lane payload and the size-to-byte-mask helper.
// Ports: none (package).
package store_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SEND  = 2'b01,
        S_SEND2 = 2'b10
    } state_e;

    // Data and byte enables of one memory beat
    typedef struct packed {
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } lane_t;

    // Byte-enable footprint of an access of the given size at offset 0
    function automatic logic [BE_W-1:0] size_mask(input size_e size);
        case (size)
            SZ_BYTE: size_mask = 4'b0001;
            SZ_HALF: size_mask = 4'b0011;
            SZ_WORD: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane placement for one store request.
// Ports:
//   offset     in  2   byte offset within the word (req_addr[1:0])
//   size       in  2   size code (store_pkg::size_e encoding)
//   data       in  32  register value
//   beat1      out     data/enables for the first (or only) beat
//   beat2      out     data/enables for the second beat of a split access
//   misaligned out 1   half/word access not naturally aligned
//   illegal    out 1   reserved size code
module store_lane_shifter
    import store_pkg::*;
(
    input  logic [1:0]        offset,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] data,
    output lane_t             beat1,
    output lane_t             beat2,
    output logic              misaligned,
    output logic              illegal
);

    size_e            sz;
    logic [BE_W-1:0]  mask;
    logic [2*BE_W-1:0] mask_wide;
    logic [2:0]       inv_off;

    assign sz        = size_e'(size);
    assign mask      = size_mask(sz);
    assign mask_wide = {4'b0000, mask};
    // Number of bytes that spill into the next word is offset; the
    // second beat takes what is left after shifting the first 4-offset out.
    assign inv_off   = 3'd4 - {1'b0, offset};

    // Aligned placement replicates the value over all lanes; misaligned
    // placement shifts it and splits the enables across two words.
    always_comb begin
        beat1      = '0;
        beat2      = '0;
        misaligned = 1'b0;
        illegal    = 1'b0;

        case (sz)
            SZ_BYTE: begin
                beat1.wdata = {4{data[7:0]}};
                beat1.be    = 4'b0001 << offset;
            end
            SZ_HALF: begin
                misaligned  = offset[0];
                beat1.wdata = {2{data[15:0]}};
                beat1.be    = offset[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                misaligned  = (offset != 2'b00);
                beat1.wdata = data;
                beat1.be    = 4'b1111;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase

        if (misaligned) begin
            beat1.wdata = data << {offset, 3'b000};
            beat1.be    = 4'(mask_wide << offset);
            beat2.wdata = data >> {inv_off, 3'b000};
            beat2.be    = mask >> inv_off;
        end
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: registers one store request and issues a
// word-aligned memory write with byte enables over valid/ready.
// Build option: STORE_SPLIT_EN -- when defined, misaligned half/word stores
// are split into two beats instead of being dropped with misalign_err.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake
//   req_addr          byte address (ADDR_W)
//   req_data          register value
//   req_size          00 byte, 01 half, 10 word, 11 illegal
//   mem_valid/ready   memory beat handshake
//   mem_addr          word-aligned address
//   mem_wdata         lane-placed data
//   mem_be            byte enables, bit i = lane i
//   misalign_err      one-cycle pulse for a dropped request
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              misalign_err
);

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    state_e            state;
    logic              split_pending;
    logic [ADDR_W-1:0] beat2_addr;
    lane_t             beat2_q;

    lane_t             lane1;
    lane_t             lane2;
    logic              misaligned;
    logic              illegal;
    logic [ADDR_W-1:0] addr_floor;
    logic [ADDR_W-1:0] addr_next;
    logic              accept;
    logic              drop;
    logic              split;

    store_lane_shifter u_shifter (
        .offset     (req_addr[1:0]),
        .size       (req_size),
        .data       (req_data),
        .beat1      (lane1),
        .beat2      (lane2),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign addr_floor = {req_addr[ADDR_W-1:2], 2'b00};
    assign addr_next  = addr_floor + ADDR_W'(4);

    // A new request may be taken while the current single beat retires
    assign req_ready = (state == S_IDLE) |
                       ((state == S_SEND) & mem_ready & ~split_pending);
    assign accept    = req_valid & req_ready;
    assign drop      = illegal | (misaligned & ~SPLIT_EN);
    assign split     = misaligned & SPLIT_EN;

    // FSM and registered memory-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            split_pending <= 1'b0;
            beat2_addr    <= '0;
            beat2_q       <= '0;
            mem_valid     <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            misalign_err  <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (accept) begin
                if (drop) begin
                    state         <= S_IDLE;
                    mem_valid     <= 1'b0;
                    split_pending <= 1'b0;
                    misalign_err  <= 1'b1;
                end else begin
                    state         <= S_SEND;
                    mem_valid     <= 1'b1;
                    mem_addr      <= addr_floor;
                    mem_wdata     <= lane1.wdata;
                    mem_be        <= lane1.be;
                    split_pending <= split;
                    beat2_addr    <= addr_next;
                    beat2_q       <= lane2;
                end
            end else begin
                case (state)
                    S_SEND: begin
                        if (mem_ready) begin
                            if (split_pending) begin
                                state         <= S_SEND2;
                                split_pending <= 1'b0;
                                mem_addr      <= beat2_addr;
                                mem_wdata     <= beat2_q.wdata;
                                mem_be        <= beat2_q.be;
                            end else begin
                                state     <= S_IDLE;
                                mem_valid <= 1'b0;
                            end
                        end
                    end
                    S_SEND2: begin
                        if (mem_ready) begin
                            state     <= S_IDLE;
                            mem_valid <= 1'b0;
                        end
                    end
                    S_IDLE: begin
                        mem_valid <= 1'b0;
                    end
                    default: begin
                        state     <= S_IDLE;
                        mem_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: directed cases with literal
// expectations, then randomized traffic against a queue-based beat model.
module tb_store_narrow_unit;

    localparam int unsigned ADDR_W = 32;

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              misalign_err;

    store_narrow_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_size     (req_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        second;
    } beat_t;

    beat_t q[$];
    logic  exp_err;
    logic  exp_rdy;
    int    n_cmp;
    int    n_bad;

    logic        snap_mv;
    logic        snap_rdy;
    logic        snap_err;
    logic [31:0] snap_addr;
    logic [31:0] snap_wdata;
    logic [3:0]  snap_be;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected beats for one accepted request, from the lane rules
    task automatic model_accept(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        int    off;
        int    mask;
        int    sh;
        beat_t b;
        logic  mis;
        off  = int'(a[1:0]);
        mis  = 1'b0;
        mask = 0;
        b.addr   = a & ~32'd3;
        b.second = 1'b0;
        case (s)
            2'd0: begin
                b.wdata = {24'd0, d[7:0]} * 32'h0101_0101;
                b.be    = 4'(1 << off);
            end
            2'd1: begin
                mis     = (off % 2) != 0;
                mask    = 3;
                b.wdata = {16'd0, d[15:0]} * 32'h0001_0001;
                b.be    = (off == 2) ? 4'hC : 4'h3;
            end
            2'd2: begin
                mis     = off != 0;
                mask    = 15;
                b.wdata = d;
                b.be    = 4'hF;
            end
            default: begin
                exp_err = 1'b1;
                return;
            end
        endcase
        if (!mis) begin
            q.push_back(b);
        end else if (!SPLIT) begin
            exp_err = 1'b1;
        end else begin
            sh      = 8 * off;
            b.wdata = d << sh;
            b.be    = 4'((mask << off) & 15);
            q.push_back(b);
            b.addr   = (a & ~32'd3) + 32'd4;
            b.wdata  = d >> (32 - sh);
            b.be     = 4'(mask >> (4 - off));
            b.second = 1'b1;
            q.push_back(b);
        end
    endtask

    // Compare every DUT output against the model for the current cycle
    task automatic check_model();
        exp_rdy = (q.size() == 0) || (q.size() == 1 && !q[0].second && mem_ready);
        chk("mem_valid", 32'(mem_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("mem_addr", mem_addr, q[0].addr);
            chk("mem_wdata", mem_wdata, q[0].wdata);
            chk("mem_be", 32'(mem_be), 32'(q[0].be));
        end
        chk("misalign_err", 32'(misalign_err), 32'(exp_err));
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        snap_mv    = mem_valid;
        snap_rdy   = req_ready;
        snap_err   = misalign_err;
        snap_addr  = mem_addr;
        snap_wdata = mem_wdata;
        snap_be    = mem_be;
    endtask

    task automatic update_model();
        logic had_beat;
        had_beat = q.size() != 0;
        if (had_beat && mem_ready) void'(q.pop_front());
        exp_err = 1'b0;
        if (req_valid && exp_rdy) model_accept(req_addr, req_size, req_data);
    endtask

    // One clock: drive on the falling edge, check, then advance the model
    task automatic step(input logic v, input logic [31:0] a, input logic [1:0] s,
                        input logic [31:0] d, input logic mr);
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        req_size  = s;
        req_data  = d;
        mem_ready = mr;
        #1;
        check_model();
        @(posedge clk);
        update_model();
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 32'd0, 2'd0, 32'd0, mr);
    endtask

    // Reset asserted mid-cycle; outputs must clear without waiting for a clock
    task automatic reset_mid(input string tag);
        @(negedge clk);
        #2;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        chk({tag, "_misalign_err"}, 32'(misalign_err), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_err   = 1'b0;
        exp_rdy   = 1'b1;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_size  = '0;
        mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_misalign_err", 32'(misalign_err), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Byte store to lane 3
        step(1'b1, 32'h0000_1003, 2'd0, 32'h1234_56AB, 1'b1);
        idle(1'b1);
        chk("byte_valid", 32'(snap_mv), 32'd1);
        chk("byte_addr", snap_addr, 32'h0000_1000);
        chk("byte_wdata", snap_wdata, 32'hABAB_ABAB);
        chk("byte_be", 32'(snap_be), 32'h8);

        // Upper halfword
        step(1'b1, 32'h0000_2002, 2'd1, 32'hFFFF_8001, 1'b1);
        idle(1'b1);
        chk("half_addr", snap_addr, 32'h0000_2000);
        chk("half_wdata", snap_wdata, 32'h8001_8001);
        chk("half_be", 32'(snap_be), 32'hC);

        // Word with three stalled cycles
        step(1'b1, 32'h0000_3000, 2'd2, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_3100, 2'd2, 32'h1111_1111, 1'b0);
            chk("stall_addr", snap_addr, 32'h0000_3000);
            chk("stall_wdata", snap_wdata, 32'hCAFE_F00D);
            chk("stall_be", 32'(snap_be), 32'hF);
            chk("stall_ready", 32'(snap_rdy), 32'd0);
        end
        idle(1'b1);
        idle(1'b1);
        chk("stall_drained", 32'(snap_mv), 32'd0);

        // Three back-to-back words at one per cycle
        step(1'b1, 32'h0000_5000, 2'd2, 32'd1, 1'b1);
        step(1'b1, 32'h0000_5004, 2'd2, 32'd2, 1'b1);
        chk("b2b_ready", 32'(snap_rdy), 32'd1);
        chk("b2b_first", snap_wdata, 32'd1);
        step(1'b1, 32'h0000_5008, 2'd2, 32'd3, 1'b1);
        chk("b2b_second", snap_wdata, 32'd2);
        idle(1'b1);
        chk("b2b_third", snap_wdata, 32'd3);
        chk("b2b_third_addr", snap_addr, 32'h0000_5008);
        idle(1'b1);

        // Misaligned word
        step(1'b1, 32'h0000_4001, 2'd2, 32'hAABB_CCDD, 1'b1);
        idle(1'b1);
        if (SPLIT) begin
            chk("split_b1_addr", snap_addr, 32'h0000_4000);
            chk("split_b1_wdata", snap_wdata, 32'hBBCC_DD00);
            chk("split_b1_be", 32'(snap_be), 32'hE);
            idle(1'b1);
            chk("split_b2_addr", snap_addr, 32'h0000_4004);
            chk("split_b2_wdata", snap_wdata, 32'h0000_00AA);
            chk("split_b2_be", 32'(snap_be), 32'h1);
        end else begin
            chk("mis_valid", 32'(snap_mv), 32'd0);
            chk("mis_err", 32'(snap_err), 32'd1);
            idle(1'b1);
            chk("mis_err_pulse", 32'(snap_err), 32'd0);
        end
        idle(1'b1);

        // Reserved size code
        step(1'b1, 32'h0000_6000, 2'd3, 32'h5555_5555, 1'b1);
        idle(1'b1);
        chk("ill_valid", 32'(snap_mv), 32'd0);
        chk("ill_err", 32'(snap_err), 32'd1);
        idle(1'b1);

        // Reset while a beat is stalled
        step(1'b1, 32'h0000_7000, 2'd2, 32'h7777_7777, 1'b0);
        idle(1'b0);
        reset_mid("rst_send");
        idle(1'b1);
        idle(1'b1);

        // Reset between split beats (plain drop in the default build)
        step(1'b1, 32'h0000_7001, 2'd2, 32'h8888_8888, 1'b1);
        idle(1'b1);
        idle(1'b0);
        reset_mid("rst_send2");
        idle(1'b1);
        chk("rst_no_beat2", 32'(snap_mv), 32'd0);
        idle(1'b1);

        // Randomized traffic, with addresses biased towards the top of the space
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            else a = $urandom;
            step($urandom_range(0, 9) < 7, a, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 9) < 8);
        end
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
